// File: rtl/cavlc_bs_byte_scheduler_if.sv
// rtl/cavlc_bs_byte_scheduler_if.sv - packer-side and sink-side signals of the byte scheduler
//
// Packer side: pk_we/pk_codebit/pk_nbytes/pk_rbsp_trailing/slice_end in, pk_ready out.
// Sink side:   bs_valid/bs_data/bs_last out, bs_ready in.
// Status:      slice_len (LEN_W) and sticky ovf_err out.
// slave  = scheduler view, master = packer/sink view.
interface cavlc_bs_byte_scheduler_if #(
    parameter int unsigned LEN_W = 20
);
    logic             pk_we;
    logic [83:0]      pk_codebit;
    logic [3:0]       pk_nbytes;
    logic [7:0]       pk_rbsp_trailing;
    logic             slice_end;
    logic             pk_ready;
    logic             bs_valid;
    logic [7:0]       bs_data;
    logic             bs_last;
    logic             bs_ready;
    logic [LEN_W-1:0] slice_len;
    logic             ovf_err;

    modport slave (
        input  pk_we, pk_codebit, pk_nbytes, pk_rbsp_trailing, slice_end, bs_ready,
        output pk_ready, bs_valid, bs_data, bs_last, slice_len, ovf_err
    );

    modport master (
        output pk_we, pk_codebit, pk_nbytes, pk_rbsp_trailing, slice_end, bs_ready,
        input  pk_ready, bs_valid, bs_data, bs_last, slice_len, ovf_err
    );
endinterface

// File: rtl/cavlc_bs_byte_scheduler.sv
// rtl/cavlc_bs_byte_scheduler.sv - two-slot beat buffer draining one byte per cycle with EPB insertion
//
// Ports:
//   clk       - single rising-edge clock
//   rst       - synchronous active-high reset
//   sched_if  - slave modport: packer beats in (pk_*), slice_end, pk_ready out;
//               byte stream out (bs_valid/bs_data/bs_last, bs_ready in);
//               slice_len of the last completed slice and sticky ovf_err.
// Parameters:
//   EPB_EN    - nonzero inserts 0x03 after two 0x00 bytes when the next byte is <= 0x03
//   LEN_W     - width of the slice byte counter
module cavlc_bs_byte_scheduler #(
    parameter int unsigned EPB_EN = 1,
    parameter int unsigned LEN_W  = 20
) (
    input logic                      clk,
    input logic                      rst,
    cavlc_bs_byte_scheduler_if.slave sched_if
);
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_EPB} state_t;

    state_t           state_q, state_d;
    logic [87:0]      slot_data_q [2];
    logic [87:0]      slot_data_d [2];
    logic [3:0]       slot_cnt_q [2];
    logic [3:0]       slot_cnt_d [2];
    logic [1:0]       slot_last_q, slot_last_d;
    logic [1:0]       slot_vld_q, slot_vld_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [3:0]       idx_q, idx_d;
    logic [1:0]       zcnt_q, zcnt_d;
    logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
    logic [LEN_W-1:0] slice_len_q, slice_len_d;
    logic             ovf_q, ovf_d;
    logic             pk_ready_q, pk_ready_d;
    logic             bs_valid_q, bs_valid_d;
    logic [7:0]       bs_data_q, bs_data_d;
    logic             bs_last_q, bs_last_d;

    logic             hs, emit_hs, slot_done, acc_req;
    logic [3:0]       nb;
    logic [87:0]      beat, head_bits;
    logic [7:0]       head_byte;
    logic [LEN_W-1:0] run_inc;
    logic             unused_bits;

    // The low nibble of the packer word never carries a byte.
    assign unused_bits = ^sched_if.pk_codebit[3:0];

    always_comb begin
        state_d     = state_q;
        slot_data_d = slot_data_q;
        slot_cnt_d  = slot_cnt_q;
        slot_last_d = slot_last_q;
        slot_vld_d  = slot_vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        zcnt_d      = zcnt_q;
        run_cnt_d   = run_cnt_q;
        slice_len_d = slice_len_q;
        ovf_d       = ovf_q;
        nb          = 4'd0;
        beat        = '0;
        run_inc     = (&run_cnt_q) ? run_cnt_q : run_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

        hs        = bs_valid_q && sched_if.bs_ready;
        emit_hs   = hs && (state_q == S_EMIT);
        slot_done = emit_hs && (idx_q == slot_cnt_q[rd_ptr_q] - 4'd1);

        // Drain side: advance through the head slot, free it after its last byte.
        if (emit_hs) begin
            if (bs_last_q)
                zcnt_d = 2'd0;
            else if (bs_data_q == 8'h00)
                zcnt_d = (zcnt_q == 2'd2) ? 2'd2 : zcnt_q + 2'd1;
            else
                zcnt_d = 2'd0;
            if (slot_done) begin
                slot_vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d             = ~rd_ptr_q;
                idx_d                = 4'd0;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end else if (hs && (state_q == S_EPB)) begin
            zcnt_d = 2'd0;
        end

        // Every handshaken byte, EPBs included, counts toward the slice length.
        if (hs) begin
            if (bs_last_q) begin
                slice_len_d = run_inc;
                run_cnt_d   = '0;
            end else begin
                run_cnt_d = run_inc;
            end
        end

        // Accept side. pk_ready_q high guarantees wr_ptr points at a free slot.
        acc_req = (sched_if.pk_we && (sched_if.pk_nbytes != 4'd0)) || sched_if.slice_end;
        if (acc_req && !pk_ready_q)
            ovf_d = 1'b1;
        if (acc_req && pk_ready_q) begin
            if (sched_if.pk_we)
                nb = (sched_if.pk_nbytes > 4'd10) ? 4'd10 : sched_if.pk_nbytes;
            beat = {sched_if.pk_codebit[83:4], 8'h00};
            for (int k = 0; k < 11; k++)
                if (sched_if.slice_end && (4'(k) == nb))
                    beat[87-8*k -: 8] = sched_if.pk_rbsp_trailing;
            slot_data_d[wr_ptr_q] = beat;
            slot_cnt_d[wr_ptr_q]  = nb + {3'b000, sched_if.slice_end};
            slot_last_d[wr_ptr_q] = sched_if.slice_end;
            slot_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d              = ~wr_ptr_q;
        end

        pk_ready_d = !(slot_vld_d[0] && slot_vld_d[1]);

        // Outputs are registered, so the byte for next cycle is picked from the
        // post-update slot state; this gives N+1 latency and no inter-slot bubble.
        head_bits = slot_data_d[rd_ptr_d] << {idx_d, 3'b000};
        head_byte = head_bits[87:80];
        if (!hs && (state_q != S_IDLE))
            state_d = state_q;
        else if (!slot_vld_d[rd_ptr_d])
            state_d = S_IDLE;
        else if ((EPB_EN != 0) && (zcnt_d == 2'd2) && (head_byte <= 8'h03))
            state_d = S_EPB;
        else
            state_d = S_EMIT;

        bs_valid_d = (state_d != S_IDLE);
        bs_data_d  = (state_d == S_EPB) ? 8'h03 : ((state_d == S_EMIT) ? head_byte : 8'h00);
        bs_last_d  = (state_d == S_EMIT) && slot_last_d[rd_ptr_d] &&
                     (idx_d == slot_cnt_d[rd_ptr_d] - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_data_q <= '{default: '0};
            slot_cnt_q  <= '{default: '0};
            slot_last_q <= '0;
            slot_vld_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            idx_q       <= 4'd0;
            zcnt_q      <= 2'd0;
            run_cnt_q   <= '0;
            slice_len_q <= '0;
            ovf_q       <= 1'b0;
            pk_ready_q  <= 1'b0;
            bs_valid_q  <= 1'b0;
            bs_data_q   <= 8'h00;
            bs_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_data_q <= slot_data_d;
            slot_cnt_q  <= slot_cnt_d;
            slot_last_q <= slot_last_d;
            slot_vld_q  <= slot_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            zcnt_q      <= zcnt_d;
            run_cnt_q   <= run_cnt_d;
            slice_len_q <= slice_len_d;
            ovf_q       <= ovf_d;
            pk_ready_q  <= pk_ready_d;
            bs_valid_q  <= bs_valid_d;
            bs_data_q   <= bs_data_d;
            bs_last_q   <= bs_last_d;
        end
    end

    assign sched_if.pk_ready  = pk_ready_q;
    assign sched_if.bs_valid  = bs_valid_q;
    assign sched_if.bs_data   = bs_data_q;
    assign sched_if.bs_last   = bs_last_q;
    assign sched_if.slice_len = slice_len_q;
    assign sched_if.ovf_err   = ovf_q;
endmodule

// File: tb/tb_cavlc_bs_byte_scheduler.sv
// tb/tb_cavlc_bs_byte_scheduler.sv - directed self-checking bench for cavlc_bs_byte_scheduler
module tb_cavlc_bs_byte_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cavlc_bs_byte_scheduler_if #(.LEN_W(20)) ifa ();
    cavlc_bs_byte_scheduler_if #(.LEN_W(20)) ifb ();

    // The EPB-disabled instance sees exactly the same stimulus.
    assign ifb.pk_we            = ifa.pk_we;
    assign ifb.pk_codebit       = ifa.pk_codebit;
    assign ifb.pk_nbytes        = ifa.pk_nbytes;
    assign ifb.pk_rbsp_trailing = ifa.pk_rbsp_trailing;
    assign ifb.slice_end        = ifa.slice_end;
    assign ifb.bs_ready         = ifa.bs_ready;

    cavlc_bs_byte_scheduler #(.EPB_EN(1), .LEN_W(20)) dut_on  (.clk(clk), .rst(rst), .sched_if(ifa));
    cavlc_bs_byte_scheduler #(.EPB_EN(0), .LEN_W(20)) dut_off (.clk(clk), .rst(rst), .sched_if(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [83:0] cb, input logic [3:0] n, input logic se, input logic [7:0] tr);
        ifa.pk_we            = 1'b1;
        ifa.pk_codebit       = cb;
        ifa.pk_nbytes        = n;
        ifa.slice_end        = se;
        ifa.pk_rbsp_trailing = tr;
    endtask

    task automatic clear_beat();
        ifa.pk_we            = 1'b0;
        ifa.pk_codebit       = '0;
        ifa.pk_nbytes        = 4'd0;
        ifa.slice_end        = 1'b0;
        ifa.pk_rbsp_trailing = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (ifa.pk_ready !== 1'b0) begin failures++; $display("FAIL reset_pk_ready got=%0h exp=0", ifa.pk_ready); end
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL reset_bs_valid got=%0h exp=0", ifa.bs_valid); end
        checks++; if (ifa.bs_data !== 8'h00) begin failures++; $display("FAIL reset_bs_data got=%0h exp=0", ifa.bs_data); end
        checks++; if (ifa.bs_last !== 1'b0) begin failures++; $display("FAIL reset_bs_last got=%0h exp=0", ifa.bs_last); end
        checks++; if (ifa.slice_len !== 20'd0) begin failures++; $display("FAIL reset_slice_len got=%0d exp=0", ifa.slice_len); end
        checks++; if (ifa.ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf_err got=%0h exp=0", ifa.ovf_err); end
        rst = 1'b0;
        tick();
        checks++; if (ifa.pk_ready !== 1'b1) begin failures++; $display("FAIL reset_release_pk_ready got=%0h exp=1", ifa.pk_ready); end
    endtask

    task automatic test_single_beat();
        logic [7:0] exp_b [3];
        exp_b = '{8'hAA, 8'hBB, 8'hCC};
        ifa.bs_ready = 1'b1;
        set_beat({24'hAABBCC, 60'h0}, 4'd3, 1'b0, 8'h00);
        tick();
        clear_beat();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d] got=%0h exp=1", i, ifa.bs_valid); end
            checks++; if (ifa.bs_data !== exp_b[i]) begin failures++; $display("FAIL single_data[%0d] got=%0h exp=%0h", i, ifa.bs_data, exp_b[i]); end
            checks++; if (ifa.bs_last !== 1'b0) begin failures++; $display("FAIL single_last[%0d] got=%0h exp=0", i, ifa.bs_last); end
            checks++; if (ifa.pk_ready !== 1'b1) begin failures++; $display("FAIL single_pk_ready[%0d] got=%0h exp=1", i, ifa.pk_ready); end
            tick();
        end
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%0h exp=0", ifa.bs_valid); end
        // A zero-byte beat without slice_end must be ignored.
        set_beat({8'h55, 76'h0}, 4'd0, 1'b0, 8'h00);
        tick();
        clear_beat();
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL empty_beat_valid got=%0h exp=0", ifa.bs_valid); end
        tick();
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL empty_beat_valid2 got=%0h exp=0", ifa.bs_valid); end
    endtask

    task automatic test_clamp();
        set_beat({80'hA0A1A2A3A4A5A6A7A8A9, 4'hF}, 4'hF, 1'b0, 8'h00);
        tick();
        clear_beat();
        for (int i = 0; i < 10; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1) begin failures++; $display("FAIL clamp_valid[%0d] got=%0h exp=1", i, ifa.bs_valid); end
            checks++; if (ifa.bs_data !== 8'(8'hA0 + i)) begin failures++; $display("FAIL clamp_data[%0d] got=%0h exp=%0h", i, ifa.bs_data, 8'(8'hA0 + i)); end
            tick();
        end
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL clamp_idle got=%0h exp=0", ifa.bs_valid); end
    endtask

    task automatic test_epb();
        logic [7:0] exp_on [9];
        logic [7:0] exp_off [7];
        exp_on  = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h05};
        exp_off = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05};
        set_beat({56'h00000100000005, 28'h0}, 4'd7, 1'b0, 8'h00);
        tick();
        clear_beat();
        for (int i = 0; i < 9; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== exp_on[i]) begin failures++; $display("FAIL epb_on[%0d] got=%0h/%0h exp=1/%0h", i, ifa.bs_valid, ifa.bs_data, exp_on[i]); end
            if (i < 7) begin
                checks++; if (ifb.bs_valid !== 1'b1 || ifb.bs_data !== exp_off[i]) begin failures++; $display("FAIL epb_off[%0d] got=%0h/%0h exp=1/%0h", i, ifb.bs_valid, ifb.bs_data, exp_off[i]); end
            end else begin
                checks++; if (ifb.bs_valid !== 1'b0) begin failures++; $display("FAIL epb_off_idle[%0d] got=%0h exp=0", i, ifb.bs_valid); end
            end
            tick();
        end
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL epb_on_idle got=%0h exp=0", ifa.bs_valid); end
    endtask

    task automatic test_slice_end();
        logic [7:0] exp_a [3];
        logic [7:0] exp_c [5];
        exp_a = '{8'h12, 8'h34, 8'h80};
        exp_c = '{8'h02, 8'h00, 8'h00, 8'h03, 8'h02};
        do_reset();
        ifa.bs_ready = 1'b1;
        set_beat({16'h1234, 68'h0}, 4'd2, 1'b1, 8'h80);
        tick();
        clear_beat();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== exp_a[i]) begin failures++; $display("FAIL slice_a_data[%0d] got=%0h/%0h exp=1/%0h", i, ifa.bs_valid, ifa.bs_data, exp_a[i]); end
            checks++; if (ifa.bs_last !== (i == 2)) begin failures++; $display("FAIL slice_a_last[%0d] got=%0h exp=%0h", i, ifa.bs_last, (i == 2)); end
            tick();
        end
        checks++; if (ifa.slice_len !== 20'd3) begin failures++; $display("FAIL slice_a_len got=%0d exp=3", ifa.slice_len); end
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL slice_a_idle got=%0h exp=0", ifa.bs_valid); end
        // Slice ending in two zeros; the next slice must start with zcnt cleared.
        set_beat({8'h00, 76'h0}, 4'd1, 1'b1, 8'h00);
        tick();
        clear_beat();
        for (int i = 0; i < 2; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== 8'h00 || ifa.bs_last !== (i == 1)) begin failures++; $display("FAIL slice_b[%0d] got=%0h/%0h/%0h exp=1/0/%0h", i, ifa.bs_valid, ifa.bs_data, ifa.bs_last, (i == 1)); end
            tick();
        end
        checks++; if (ifa.slice_len !== 20'd2) begin failures++; $display("FAIL slice_b_len got=%0d exp=2", ifa.slice_len); end
        set_beat({32'h02000002, 52'h0}, 4'd4, 1'b0, 8'h00);
        tick();
        clear_beat();
        for (int i = 0; i < 5; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== exp_c[i] || ifa.bs_last !== 1'b0) begin failures++; $display("FAIL slice_c[%0d] got=%0h/%0h/%0h exp=1/%0h/0", i, ifa.bs_valid, ifa.bs_data, ifa.bs_last, exp_c[i]); end
            tick();
        end
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL slice_c_idle got=%0h exp=0", ifa.bs_valid); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        ifa.bs_ready = 1'b0;
        set_beat({80'h0102030405060708090A, 4'h0}, 4'd10, 1'b0, 8'h00);
        tick();
        checks++; if (ifa.pk_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 got=%0h exp=1", ifa.pk_ready); end
        set_beat({80'h0B0C0D0E0F1011121314, 4'h0}, 4'd10, 1'b0, 8'h00);
        tick();
        checks++; if (ifa.pk_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after2 got=%0h exp=0", ifa.pk_ready); end
        checks++; if (ifa.ovf_err !== 1'b0) begin failures++; $display("FAIL bp_ovf_early got=%0h exp=0", ifa.ovf_err); end
        set_beat({80'h15161718191A1B1C1D1E, 4'h0}, 4'd10, 1'b0, 8'h00);
        tick();
        clear_beat();
        checks++; if (ifa.ovf_err !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%0h exp=1", ifa.ovf_err); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== 8'h01 || ifa.bs_last !== 1'b0) begin failures++; $display("FAIL bp_stall[%0d] got=%0h/%0h/%0h exp=1/01/0", i, ifa.bs_valid, ifa.bs_data, ifa.bs_last); end
            tick();
        end
        ifa.bs_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== 8'(i + 1)) begin failures++; $display("FAIL bp_drain[%0d] got=%0h/%0h exp=1/%0h", i, ifa.bs_valid, ifa.bs_data, 8'(i + 1)); end
            tick();
        end
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL bp_idle got=%0h exp=0", ifa.bs_valid); end
        checks++; if (ifa.pk_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_end got=%0h exp=1", ifa.pk_ready); end
        checks++; if (ifa.ovf_err !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%0h exp=1", ifa.ovf_err); end
    endtask

    task automatic test_reset_mid_drain();
        ifa.bs_ready = 1'b1;
        set_beat({80'hA0A10000A4A5A6A7A8A9, 4'h0}, 4'd10, 1'b0, 8'h00);
        tick();
        clear_beat();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== 8'hA4) begin failures++; $display("FAIL mid_pending got=%0h/%0h exp=1/a4", ifa.bs_valid, ifa.bs_data); end
        rst = 1'b1;
        tick();
        checks++; if (ifa.pk_ready !== 1'b0 || ifa.bs_valid !== 1'b0 || ifa.bs_data !== 8'h00) begin failures++; $display("FAIL mid_reset_a got=%0h/%0h/%0h exp=0/0/0", ifa.pk_ready, ifa.bs_valid, ifa.bs_data); end
        checks++; if (ifa.bs_last !== 1'b0 || ifa.slice_len !== 20'd0 || ifa.ovf_err !== 1'b0) begin failures++; $display("FAIL mid_reset_b got=%0h/%0d/%0h exp=0/0/0", ifa.bs_last, ifa.slice_len, ifa.ovf_err); end
        rst = 1'b0;
        tick();
        checks++; if (ifa.pk_ready !== 1'b1 || ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL mid_release got=%0h/%0h exp=1/0", ifa.pk_ready, ifa.bs_valid); end
        // zcnt was 2 before reset; a byte 0x01 now must not be preceded by an EPB.
        set_beat({16'h0102, 68'h0}, 4'd2, 1'b0, 8'h00);
        tick();
        clear_beat();
        checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== 8'h01) begin failures++; $display("FAIL mid_fresh0 got=%0h/%0h exp=1/01", ifa.bs_valid, ifa.bs_data); end
        tick();
        checks++; if (ifa.bs_valid !== 1'b1 || ifa.bs_data !== 8'h02) begin failures++; $display("FAIL mid_fresh1 got=%0h/%0h exp=1/02", ifa.bs_valid, ifa.bs_data); end
        tick();
        checks++; if (ifa.bs_valid !== 1'b0) begin failures++; $display("FAIL mid_fresh_idle got=%0h exp=0", ifa.bs_valid); end
    endtask

    initial begin
        clear_beat();
        ifa.bs_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_clamp();
        test_epb();
        test_slice_end();
        test_back_pressure();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
